// File: rtl/tpu_acc_pkg.sv
// Shared types and defaults for the systolic-array result accumulator.
// State encoding, default lane widths and the lane-slice helper.
package tpu_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } acc_state_e;

  localparam int DEF_MATRIX_SIZE    = 8;
  localparam int DEF_PARTIAL_SUM_BW = 20;
  localparam int DEF_ACC_BW         = 24;

  function automatic int lane_lsb(
    input int lane,
    input int width
  );
    return lane * width;
  endfunction

endpackage

// File: rtl/acc_lane.sv
// One accumulator lane: sign-extend, add, optional saturation.
// Saturation on signed overflow is built when ACC_SATURATE_EN is defined.
module acc_lane
  import tpu_acc_pkg::*;
#(
  parameter int PSUM_BW = DEF_PARTIAL_SUM_BW,
  parameter int ACC_W   = DEF_ACC_BW
) (
  input  logic               overwrite_i,
  input  logic [PSUM_BW-1:0] psum_i,
  input  logic [ACC_W-1:0]   acc_i,
  output logic [ACC_W-1:0]   sum_o
);

  logic signed [ACC_W-1:0] ext;
  logic signed [ACC_W-1:0] raw;
  logic        [ACC_W-1:0] sum_add;

  assign ext = ACC_W'($signed(psum_i));
  assign raw = $signed(acc_i) + ext;

`ifdef ACC_SATURATE_EN
  logic             ovf;
  logic [ACC_W-1:0] sat;

  // Overflow only when both operands share a sign the result lost.
  assign ovf = (acc_i[ACC_W-1] == ext[ACC_W-1]) &&
               (raw[ACC_W-1] != acc_i[ACC_W-1]);
  assign sat = acc_i[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                              : {1'b0, {(ACC_W-1){1'b1}}};
  assign sum_add = ovf ? sat : raw;
`else
  assign sum_add = raw;
`endif

  always_comb begin
    sum_o = sum_add;
    if (overwrite_i) begin
      sum_o = ext;
    end
  end

endmodule

// File: rtl/result_accumulator.sv
// K-tile partial-sum accumulator with row buffer and valid/ready drain.
// Build option: ACC_SATURATE_EN selects saturating lane adds.
module result_accumulator
  import tpu_acc_pkg::*;
#(
  parameter int MATRIX_SIZE    = DEF_MATRIX_SIZE,
  parameter int PARTIAL_SUM_BW = DEF_PARTIAL_SUM_BW,
  parameter int ACC_BW         = DEF_ACC_BW,
  parameter int DEPTH          = 16,
  parameter int ADDR_BW        = 4,
  parameter int TILE_BW        = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [ADDR_BW-1:0]                  cfg_rows,
  input  logic [TILE_BW-1:0]                  cfg_tiles,
  input  logic                                in_valid,
  input  logic [MATRIX_SIZE*PARTIAL_SUM_BW-1:0] in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [MATRIX_SIZE*ACC_BW-1:0]       out_data,
  output logic [ADDR_BW-1:0]                  out_row,
  output logic                                busy,
  output logic                                done,
  output logic                                err
);

  localparam int ROW_W = MATRIX_SIZE * ACC_BW;

  acc_state_e         state_q, state_d;
  logic [ADDR_BW-1:0] row_ptr_q, row_ptr_d;
  logic [TILE_BW-1:0] tile_cnt_q, tile_cnt_d;
  logic [ADDR_BW-1:0] cfg_rows_q, cfg_rows_d;
  logic [TILE_BW-1:0] cfg_tiles_q, cfg_tiles_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               out_valid_q, out_valid_d;
  logic [ADDR_BW-1:0] out_row_q, out_row_d;
  logic [ROW_W-1:0]   out_data_q, out_data_d;

  logic [ROW_W-1:0]   buf_q [DEPTH];
  logic [ROW_W-1:0]   cur_row;
  logic [ROW_W-1:0]   new_row;
  logic [ROW_W-1:0]   rd_row;
  logic [ADDR_BW-1:0] rd_addr;
  logic               wr_en;
  logic               first_tile;

  assign wr_en      = (state_q == ACCUM) && in_valid;
  assign first_tile = (tile_cnt_q == '0);
  assign cur_row    = buf_q[row_ptr_q];

  for (genvar l = 0; l < MATRIX_SIZE; l++) begin : g_lane
    acc_lane #(
      .PSUM_BW(PARTIAL_SUM_BW),
      .ACC_W  (ACC_BW)
    ) u_lane (
      .overwrite_i(first_tile),
      .psum_i     (in_data[lane_lsb(l, PARTIAL_SUM_BW) +: PARTIAL_SUM_BW]),
      .acc_i      (cur_row[lane_lsb(l, ACC_BW) +: ACC_BW]),
      .sum_o      (new_row[lane_lsb(l, ACC_BW) +: ACC_BW])
    );
  end

  // Buffer contents survive reset; tile 0 always overwrites.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_q[row_ptr_q] <= new_row;
    end
  end

  // Read address leads the presented row by one.
  assign rd_addr = out_valid_q ? out_row_q + ADDR_BW'(1) : '0;
  assign rd_row  = buf_q[rd_addr];

  always_comb begin
    state_d     = state_q;
    row_ptr_d   = row_ptr_q;
    tile_cnt_d  = tile_cnt_q;
    cfg_rows_d  = cfg_rows_q;
    cfg_tiles_d = cfg_tiles_q;
    err_d       = err_q;
    done_d      = 1'b0;
    out_valid_d = out_valid_q;
    out_row_d   = out_row_q;
    out_data_d  = out_data_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = ACCUM;
          cfg_rows_d  = cfg_rows;
          cfg_tiles_d = cfg_tiles;
          row_ptr_d   = '0;
          tile_cnt_d  = '0;
          err_d       = 1'b0;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          if (row_ptr_q == cfg_rows_q) begin
            row_ptr_d = '0;
            if (tile_cnt_q == cfg_tiles_q) begin
              state_d     = DRAIN;
              tile_cnt_d  = '0;
              out_valid_d = 1'b0;
            end else begin
              tile_cnt_d = tile_cnt_q + TILE_BW'(1);
            end
          end else begin
            row_ptr_d = row_ptr_q + ADDR_BW'(1);
          end
        end
      end
      DRAIN: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_row_d   = '0;
          out_data_d  = rd_row;
        end else if (out_ready) begin
          if (out_row_q == cfg_rows_q) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
            done_d      = 1'b1;
          end else begin
            out_row_d  = out_row_q + ADDR_BW'(1);
            out_data_d = rd_row;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (in_valid && (state_q != ACCUM)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      row_ptr_q   <= '0;
      tile_cnt_q  <= '0;
      cfg_rows_q  <= '0;
      cfg_tiles_q <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      row_ptr_q   <= row_ptr_d;
      tile_cnt_q  <= tile_cnt_d;
      cfg_rows_q  <= cfg_rows_d;
      cfg_tiles_q <= cfg_tiles_d;
      err_q       <= err_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_result_accumulator.sv
// Bench for result_accumulator: 24-bit and 20-bit instances in lockstep.
// Expected rows come from an arithmetic model of the tile sums.
module tb_result_accumulator;

  localparam int N  = 8;
  localparam int PW = 20;
  localparam int AW = 24;
  localparam int BW = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, start, in_valid, out_ready;
  logic [3:0]      cfg_rows, cfg_tiles;
  logic [N*PW-1:0] in_data;

  logic            ov_a, busy_a, done_a, err_a;
  logic [N*AW-1:0] od_a;
  logic [3:0]      or_a;
  logic            ov_b, busy_b, done_b, err_b;
  logic [N*BW-1:0] od_b;
  logic [3:0]      or_b;

  result_accumulator dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_rows(cfg_rows), .cfg_tiles(cfg_tiles),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov_a), .out_ready(out_ready),
    .out_data(od_a), .out_row(or_a),
    .busy(busy_a), .done(done_a), .err(err_a)
  );

  result_accumulator #(.ACC_BW(BW)) dut20 (
    .clk(clk), .rst(rst), .start(start),
    .cfg_rows(cfg_rows), .cfg_tiles(cfg_tiles),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov_b), .out_ready(out_ready),
    .out_data(od_b), .out_row(or_b),
    .busy(busy_b), .done(done_b), .err(err_b)
  );

  int     tests = 0;
  int     fails = 0;
  int     vals [16][16][N];
  longint exp_a [16][N];
  longint exp_b [16][N];

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic longint wrapv(input longint s, input int bw);
    longint m;
    m = longint'(1) << bw;
    s = s & (m - 1);
    if (s >= (m >> 1)) s = s - m;
    return s;
  endfunction

  function automatic longint addm(input longint a, input longint x,
                                  input int bw);
    longint s;
    s = a + x;
`ifdef ACC_SATURATE_EN
    if (s > (longint'(1) << (bw - 1)) - 1) s = (longint'(1) << (bw - 1)) - 1;
    if (s < -(longint'(1) << (bw - 1))) s = -(longint'(1) << (bw - 1));
    return s;
`else
    return wrapv(s, bw);
`endif
  endfunction

  function automatic int rnd20();
    int v;
    v = int'($urandom_range(0, 20'hFFFFF));
    if (v >= 524288) v = v - 1048576;
    return v;
  endfunction

  task automatic build_model(input int R, input int T);
    for (int r = 0; r <= R; r++) begin
      for (int l = 0; l < N; l++) begin
        exp_a[r][l] = wrapv(longint'(vals[0][r][l]), AW);
        exp_b[r][l] = wrapv(longint'(vals[0][r][l]), BW);
        for (int t = 1; t <= T; t++) begin
          exp_a[r][l] = addm(exp_a[r][l], longint'(vals[t][r][l]), AW);
          exp_b[r][l] = addm(exp_b[r][l], longint'(vals[t][r][l]), BW);
        end
      end
    end
  endtask

  task automatic fill_random(input int R, input int T);
    for (int t = 0; t <= T; t++)
      for (int r = 0; r <= R; r++)
        for (int l = 0; l < N; l++)
          vals[t][r][l] = rnd20();
  endtask

  task automatic do_start(input int R, input int T);
    start     = 1'b1;
    cfg_rows  = 4'(R);
    cfg_tiles = 4'(T);
    @(posedge clk); #1;
    start     = 1'b0;
    cfg_rows  = 4'($urandom);
    cfg_tiles = 4'($urandom);
    @(negedge clk);
    check("start_busy", {62'd0, busy_a, busy_b}, 64'd3);
    check("start_err", {62'd0, err_a, err_b}, 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic feed(input int R, input int T, input bit gaps,
                      input bit inject);
    for (int t = 0; t <= T; t++) begin
      for (int r = 0; r <= R; r++) begin
        if (gaps && $urandom_range(0, 2) == 0) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
        in_valid = 1'b1;
        for (int l = 0; l < N; l++) in_data[l*PW +: PW] = vals[t][r][l][PW-1:0];
        if (inject && t == 0 && r == 0) begin
          start     = 1'b1;
          cfg_rows  = 4'(R + 1);
          cfg_tiles = 4'(T + 1);
        end
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int R, input int mode);
    int              got = 0;
    int              cyc = 0;
    int              first = -1;
    bit              held = 0;
    logic [N*AW-1:0] hd_a, er_a;
    logic [N*BW-1:0] hd_b, er_b;
    logic [3:0]      hr;
    while (got <= R && cyc < 100) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: begin
          out_ready = 1'($urandom_range(0, 1));
          in_valid  = (cyc == 0) ? 1'b1 : 1'($urandom_range(0, 1));
          in_data   = {5{$urandom}};
        end
      endcase
      @(negedge clk);
      if (held) begin
        tests++;
        assert (od_a === hd_a && od_b === hd_b && or_a === hr) else begin
          fails++;
          $error("FAIL stall_hold: row %0d/%0h changed from %0d/%0h",
                 or_a, od_a, hr, hd_a);
        end
      end
      held = 0;
      if (ov_a && first < 0) first = cyc;
      if (ov_a) begin
        if (out_ready) begin
          for (int l = 0; l < N; l++) begin
            er_a[l*AW +: AW] = exp_a[got][l][AW-1:0];
            er_b[l*BW +: BW] = exp_b[got][l][BW-1:0];
          end
          check("out_row", {56'd0, or_a, or_b}, {56'd0, 4'(got), 4'(got)});
          check("ov_b", {63'd0, ov_b}, 64'd1);
          tests++;
          assert (od_a === er_a) else begin
            fails++;
            $error("FAIL row24[%0d]: got %0h expected %0h", got, od_a, er_a);
          end
          tests++;
          assert (od_b === er_b) else begin
            fails++;
            $error("FAIL row20[%0d]: got %0h expected %0h", got, od_b, er_b);
          end
          got++;
        end else begin
          held = 1;
          hd_a = od_a;
          hd_b = od_b;
          hr   = or_a;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("drain_timeout", 64'(got), 64'(R + 1));
    check("first_valid_lat", 64'(first), 64'd1);
    @(negedge clk);
    check("done_pulse", {60'd0, done_a, done_b, busy_a, busy_b}, 64'b1100);
    check("err_end", {62'd0, err_a, err_b},
          (mode == 2) ? 64'd3 : 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("done_low", {62'd0, done_a, done_b}, 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic job(input int R, input int T, input int mode,
                     input bit gaps, input bit inject);
    build_model(R, T);
    do_start(R, T);
    feed(R, T, gaps, inject);
    drain(R, mode);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cfg_rows = '0; cfg_tiles = '0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_flags", {58'd0, ov_a, busy_a, done_a, err_a, ov_b, busy_b},
          64'd0);
    check("rst_data", 64'(od_a), 64'd0);
    check("rst_row", {56'd0, or_a, or_b}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int l = 0; l < N; l++) begin
      vals[0][0][l] = 5;
      vals[0][1][l] = -3;
    end
    job(1, 0, 0, 0, 0);

    for (int l = 0; l < N; l++) begin
      vals[0][0][l] = l;
      vals[1][0][l] = 10 * l;
      vals[2][0][l] = 100 * l;
    end
    job(0, 2, 0, 0, 0);
    check("lane7_111", 64'(od_a[7*AW +: AW]), 64'd777);

    fill_random(3, 0);
    job(3, 0, 1, 0, 0);

    for (int l = 0; l < N; l++) begin
      vals[0][0][l] = 20'h7FFFF;
      vals[1][0][l] = 20'h7FFFF;
    end
    job(0, 1, 0, 0, 0);
`ifdef ACC_SATURATE_EN
    check("ovf20_sat", 64'(od_b[BW-1:0]), 64'h7FFFF);
`else
    check("ovf20_wrap", 64'(od_b[BW-1:0]), 64'hFFFFE);
`endif
    check("ovf24", 64'(od_a[AW-1:0]), 64'hFFFFE);

    in_valid = 1'b1;
    in_data  = {5{$urandom}};
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("idle_err", {60'd0, err_a, err_b, busy_a, busy_b}, 64'b1100);
    @(posedge clk); #1;

    fill_random(2, 1);
    job(2, 1, 0, 1, 1);

    fill_random(3, 0);
    job(3, 0, 2, 0, 0);

    fill_random(3, 1);
    do_start(3, 1);
    feed(1, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_flags", {58'd0, ov_a, busy_a, done_a, err_a, ov_b, busy_b},
          64'd0);
    check("midrst_data", {56'd0, or_a, or_b}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    fill_random(3, 1);
    job(3, 1, 0, 0, 0);

    for (int k = 0; k < 4; k++) begin
      int r, t;
      r = int'($urandom_range(0, 5));
      t = int'($urandom_range(0, 3));
      fill_random(r, t);
      job(r, t, int'($urandom_range(0, 1)), 1, 0);
    end

    fill_random(15, 0);
    job(15, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/result_accumulator.md
Name: result_accumulator

Overview:
Downstream consumer of the systolic array's deskewed result rows (MATRIX_SIZE lanes x PARTIAL_SUM_BW). Sums partial-sum rows across K-tiles into an on-chip row buffer. Drains the finished rows over a valid/ready stream toward the results SRAM write port. Replaces the bare count-based write-enable with an explicit tile/row sequencer.

Parameters:
MATRIX_SIZE, 8, lanes per row
PARTIAL_SUM_BW, 20, signed width of each incoming lane
ACC_BW, 24, signed width of each accumulator lane (must be >= PARTIAL_SUM_BW)
DEPTH, 16, accumulator rows held
ADDR_BW, 4, log2(DEPTH)
TILE_BW, 4, width of tile-count field

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  1-cycle pulse; latches cfg_rows/cfg_tiles; accepted only in IDLE
cfg_rows  in  ADDR_BW  rows per tile minus 1
cfg_tiles  in  TILE_BW  tiles to accumulate minus 1
in_valid  in  1  incoming result row valid (no backpressure)
in_data  in  MATRIX_SIZE*PARTIAL_SUM_BW  lane i at bits [i*PSUM+:PSUM], signed
out_valid  out  1  drained row valid
out_ready  in  1  downstream accepts row
out_data  out  MATRIX_SIZE*ACC_BW  accumulated row, same lane packing
out_row  out  ADDR_BW  row index of out_data
busy  out  1  high when not IDLE
done  out  1  1-cycle pulse after last row handshake
err  out  1  sticky: in_valid seen outside ACCUM; cleared by rst or accepted start

Behaviour:
- Reset: state IDLE; out_valid, out_data, out_row, busy, done, err all 0; counters 0. Buffer contents are not reset.
- Reset mid-operation: abort immediately to IDLE; partial sums are discarded.
- FSM states: IDLE, ACCUM, DRAIN.
  - IDLE -> ACCUM on start. The accepted start clears err, row_ptr, and tile_cnt.
  - ACCUM -> DRAIN on the in_valid cycle where row_ptr==cfg_rows and tile_cnt==cfg_tiles.
  - DRAIN -> IDLE the cycle after the handshake on row cfg_rows. done pulses in that cycle.
- ACCUM, each in_valid cycle:
  - lane = sign_extend(in_data lane) when tile_cnt==0 (overwrite, no clear pass needed);
  - otherwise lane = buf[row_ptr] lane + sign_extend(in lane).
  - Written at the clock edge.
  - row_ptr increments and wraps to 0 after cfg_rows. tile_cnt increments on that wrap.
- Arithmetic: two's complement, ACC_BW result. Wraps modulo 2^ACC_BW (see optional feature).
- DRAIN:
  - Rows are read in order 0..cfg_rows. Buffer read latency is 1 cycle.
  - out_valid rises no later than 2 cycles after entering DRAIN.
  - out_data/out_row are held stable while out_valid && !out_ready.
  - A new row is presented the cycle after each handshake, so back-to-back throughput is 1 row/cycle with out_ready tied high.
- Ignored inputs:
  - in_valid in IDLE or DRAIN is ignored, sets err, and leaves the buffer unchanged.
  - start while busy is ignored; err is unaffected.
- cfg_rows=0 and cfg_tiles=0 are legal (1 row, 1 tile).
- cfg values are captured at start; later changes on the cfg inputs have no effect.

Optional Feature:
ACC_SATURATE_EN: when defined, each lane add saturates to +(2^(ACC_BW-1)-1) / -2^(ACC_BW-1) on signed overflow. When undefined, lanes wrap modulo 2^ACC_BW. Overwrite (tile 0) is unaffected in both cases.

Decomposition:
- Package tpu_acc_pkg holds:
  - state encoding (IDLE=2'd0, ACCUM=2'd1, DRAIN=2'd2);
  - default widths (MATRIX_SIZE, PARTIAL_SUM_BW, ACC_BW);
  - the lane-slice helper function.
- Sub-module acc_lane (combinational):
  - sign-extend, add, optional saturation;
  - one instance per lane via generate.
- Buffer: behavioral register array, DEPTH x MATRIX_SIZE*ACC_BW, inferred in the top.

Test Plan:
- Single tile: cfg_rows=1, cfg_tiles=0, rows {all lanes 5},{all lanes -3} -> drained rows 5 then -3 (24-bit 0xFFFFFD), out_row 0,1; done pulses once; busy falls the same cycle.
- Three tiles: cfg_rows=0, cfg_tiles=2, lane i inputs i, 10*i, 100*i -> drained lane i = 111*i.
- Backpressure: 4 rows drained with out_ready toggling 1,0,0,1,... -> every row appears exactly once, in order; out_data stable during stalls.
- Overflow: cfg_tiles=1, lanes 0x7FFFF twice, then with ACC_BW=20 -> wrap build gives 0xFFFFE; ACC_SATURATE_EN build gives 0x7FFFF.
- Protocol errors: in_valid in IDLE -> err=1, buffer unchanged. start during ACCUM -> ignored. Next accepted start -> err=0.
- Reset mid-ACCUM after 2 of 4 rows -> all outputs 0, state IDLE. A fresh run then overwrites correctly with no stale sums.
